// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the 8227 interrupt/reset entry sequencer.
package int_seq_pkg;

  typedef enum logic [1:0] {IDLE, SEQ, DONE} seqState_t;

  typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_BRK, SRC_IRQ} seqSrc_t;

  localparam logic [1:0] PUSH_PCH = 2'd0;
  localparam logic [1:0] PUSH_PCL = 2'd1;
  localparam logic [1:0] PUSH_P   = 2'd2;

  localparam logic [7:0] DEF_NMI_VEC_LO = 8'hFA;
  localparam logic [7:0] DEF_RST_VEC_LO = 8'hFC;
  localparam logic [7:0] DEF_IRQ_VEC_LO = 8'hFE;

  localparam logic [2:0] LAST_PUSH_STEP = 3'd4;
  localparam logic [2:0] FETCH_LO_STEP  = 3'd5;
  localparam logic [2:0] FETCH_HI_STEP  = 3'd6;

  function automatic logic isPushStep(input logic [2:0] step);
    return (step >= 3'd2) && (step <= 3'd4);
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pin/decoder inputs and per-cycle datapath strobes of the interrupt sequencer.
interface interrupt_sequencer_if;
  logic       nonMaskableInterrupt;
  logic       interruptRequest;
  logic       instrBoundary;
  logic       breakDecoded;
  logic       iFlag;
  logic       seqActive;
  logic [2:0] seqStep;
  logic       stackWrite;
  logic       stackDecOnly;
  logic [1:0] pushSel;
  logic       pushBreakBit;
  logic [7:0] vectorAddrLow;
  logic [1:0] vectorFetch;
  logic       setIFlag;
  logic       seqDone;

  modport master (
    input  nonMaskableInterrupt, interruptRequest, instrBoundary, breakDecoded, iFlag,
    output seqActive, seqStep, stackWrite, stackDecOnly, pushSel, pushBreakBit,
           vectorAddrLow, vectorFetch, setIFlag, seqDone
  );

  modport slave (
    output nonMaskableInterrupt, interruptRequest, instrBoundary, breakDecoded, iFlag,
    input  seqActive, seqStep, stackWrite, stackDecOnly, pushSel, pushBreakBit,
           vectorAddrLow, vectorFetch, setIFlag, seqDone
  );
endinterface

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// NMI pin synchronizer, 0->1 edge detector and sticky pending flag.
module nmi_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic pin,
  input  logic clr,
  output logic pending
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;
  logic                   rise;

  assign rise = syncQ[SYNC_STAGES-1] & ~prevQ;

  // A fresh edge in the same cycle as a clear wins, so it is not lost.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      syncQ   <= '0;
      prevQ   <= 1'b0;
      pending <= 1'b0;
    end else begin
      syncQ[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
      prevQ   <= syncQ[SYNC_STAGES-1];
      pending <= rise | (pending & ~clr);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer: 7-step stack push and vector fetch that redirects the PC.
module interrupt_sequencer
  import int_seq_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] NMI_VEC_LO  = DEF_NMI_VEC_LO,
  parameter logic [7:0] RST_VEC_LO  = DEF_RST_VEC_LO,
  parameter logic [7:0] IRQ_VEC_LO  = DEF_IRQ_VEC_LO
) (
  input  logic                  clk,
  input  logic                  nrst,
  interrupt_sequencer_if.master bus
);

  seqState_t state, stateNxt;
  seqSrc_t   src, srcNxt;
  logic [2:0] step, stepNxt;
  logic [7:0] vecLo, vecLoNxt;
  logic       rstPending, rstPendingNxt;
  logic [SYNC_STAGES-1:0] irqSync;
  logic       nmiPending, nmiClr;

  logic       seqActive, stackWrite, stackDecOnly, pushBreakBit, setIFlag, seqDone;
  logic [2:0] seqStep;
  logic [1:0] pushSel, vectorFetch;
  logic [7:0] vectorAddrLow;

  nmi_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) uNmi (
    .clk     (clk),
    .nrst    (nrst),
    .pin     (bus.nonMaskableInterrupt),
    .clr     (nmiClr),
    .pending (nmiPending)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      src        <= SRC_RST;
      step       <= 3'd0;
      vecLo      <= RST_VEC_LO;
      rstPending <= 1'b1;
      irqSync    <= '0;
    end else begin
      state      <= stateNxt;
      src        <= srcNxt;
      step       <= stepNxt;
      vecLo      <= vecLoNxt;
      rstPending <= rstPendingNxt;
      irqSync[0] <= bus.interruptRequest;
      for (int i = 1; i < SYNC_STAGES; i++) irqSync[i] <= irqSync[i-1];
    end
  end

  always_comb begin
    stateNxt      = state;
    srcNxt        = src;
    stepNxt       = step;
    vecLoNxt      = vecLo;
    rstPendingNxt = rstPending;
    nmiClr        = 1'b0;
    seqActive     = 1'b0;
    seqStep       = 3'd0;
    stackWrite    = 1'b0;
    stackDecOnly  = 1'b0;
    pushSel       = PUSH_PCH;
    pushBreakBit  = 1'b0;
    vectorAddrLow = 8'h00;
    vectorFetch   = 2'b00;
    setIFlag      = 1'b0;
    seqDone       = 1'b0;

    unique case (state)
      IDLE: begin
        // Reset entry does not wait for an instruction boundary.
        if (rstPending) begin
          stateNxt      = SEQ;
          stepNxt       = 3'd0;
          srcNxt        = SRC_RST;
          vecLoNxt      = RST_VEC_LO;
          rstPendingNxt = 1'b0;
        end else if (bus.instrBoundary) begin
          if (nmiPending) begin
            stateNxt = SEQ;
            stepNxt  = 3'd0;
            srcNxt   = SRC_NMI;
            vecLoNxt = NMI_VEC_LO;
          end else if (bus.breakDecoded) begin
            stateNxt = SEQ;
            stepNxt  = 3'd0;
            srcNxt   = SRC_BRK;
            vecLoNxt = IRQ_VEC_LO;
          end else if (irqSync[SYNC_STAGES-1] && !bus.iFlag) begin
            stateNxt = SEQ;
            stepNxt  = 3'd0;
            srcNxt   = SRC_IRQ;
            vecLoNxt = IRQ_VEC_LO;
          end
        end
      end

      SEQ: begin
        seqActive = 1'b1;
        seqStep   = step;
        if (isPushStep(step)) begin
          stackWrite   = (src != SRC_RST);
          stackDecOnly = (src == SRC_RST);
          pushSel      = step[1:0] - 2'd2;
          pushBreakBit = (step == LAST_PUSH_STEP) && (src == SRC_BRK);
        end
        // Last chance for an NMI to hijack IRQ/BRK; pending clears as step 5 is entered.
        if (step == LAST_PUSH_STEP && (src == SRC_NMI || (src != SRC_RST && nmiPending))) begin
          vecLoNxt = NMI_VEC_LO;
          nmiClr   = 1'b1;
        end
        if (step == FETCH_LO_STEP) begin
          vectorAddrLow = vecLo;
          vectorFetch   = 2'b01;
          setIFlag      = 1'b1;
        end
        if (step == FETCH_HI_STEP) begin
          vectorAddrLow = vecLo + 8'd1;
          vectorFetch   = 2'b10;
          stateNxt      = DONE;
          stepNxt       = 3'd0;
        end else begin
          stepNxt = step + 3'd1;
        end
      end

      DONE: begin
        seqDone  = 1'b1;
        stateNxt = IDLE;
      end

      default: stateNxt = IDLE;
    endcase
  end

  assign bus.seqActive     = seqActive;
  assign bus.seqStep       = seqStep;
  assign bus.stackWrite    = stackWrite;
  assign bus.stackDecOnly  = stackDecOnly;
  assign bus.pushSel       = pushSel;
  assign bus.pushBreakBit  = pushBreakBit;
  assign bus.vectorAddrLow = vectorAddrLow;
  assign bus.vectorFetch   = vectorFetch;
  assign bus.setIFlag      = setIFlag;
  assign bus.seqDone       = seqDone;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: expected per-cycle strobes queued at stimulus, checked by a monitor.
module tb_interrupt_sequencer;

  logic tb_clk = 1'b0;
  logic nrst   = 1'b0;
  always #5 tb_clk = ~tb_clk;

  interrupt_sequencer_if bus();

  interrupt_sequencer dut (
    .clk  (tb_clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [20:0] v;
  } expRec_t;

  expRec_t sb[$];
  int testsRun    = 0;
  int testsFailed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // {active, step, sw, decOnly, pushSel, bBit, vecLo, fetch, setI, done}
  function automatic logic [20:0] pk();
    return {bus.seqActive, bus.seqStep, bus.stackWrite, bus.stackDecOnly, bus.pushSel,
            bus.pushBreakBit, bus.vectorAddrLow, bus.vectorFetch, bus.setIFlag, bus.seqDone};
  endfunction

  // Expected trace of one entry sequence from the behavioural description; nRec truncates it.
  task automatic mkSeq(input string name, input bit isRst, input bit brk,
                       input logic [7:0] vec, input int nRec);
    expRec_t e;
    for (int s = 0; s < 8 && s < nRec; s++) begin
      logic       push;
      logic [1:0] ps;
      logic [7:0] va;
      logic [1:0] vf;
      push = (s >= 2 && s <= 4);
      ps   = push ? 2'(s - 2) : 2'd0;
      va   = (s == 5) ? vec : (s == 6) ? vec + 8'd1 : 8'h00;
      vf   = (s == 5) ? 2'b01 : (s == 6) ? 2'b10 : 2'b00;
      e.tag = $sformatf("%s s%0d", name, s);
      if (s == 7)
        e.v = {1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1};
      else
        e.v = {1'b1, 3'(s), push & ~isRst, push & isRst, ps, brk && (s == 4), va, vf, s == 5, 1'b0};
      sb.push_back(e);
    end
  endtask

  always @(negedge tb_clk) begin
    if (nrst && (bus.seqActive || bus.seqDone)) begin
      if (sb.size() == 0) chk("unexpected", 32'(pk()), 32'd0);
      else begin
        expRec_t e;
        e = sb.pop_front();
        chk(e.tag, 32'(pk()), 32'(e.v));
      end
    end
  end

  task automatic boundary(input bit brk);
    @(negedge tb_clk);
    bus.instrBoundary = 1'b1;
    bus.breakDecoded  = brk;
    @(negedge tb_clk);
    bus.instrBoundary = 1'b0;
    bus.breakDecoded  = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.seqActive || bus.seqDone) && n < 40) begin
      @(negedge tb_clk);
      #1;
      n++;
    end
    chk({tag, " drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.nonMaskableInterrupt = 1'b0;
    bus.interruptRequest     = 1'b0;
    bus.instrBoundary        = 1'b0;
    bus.breakDecoded         = 1'b0;
    bus.iFlag                = 1'b0;

    // Power-on reset and boot sequence
    idleCycles(2);
    chk("reset outs", 32'(pk()), 32'd0);
    mkSeq("boot", 1'b1, 1'b0, 8'hFC, 8);
    nrst = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge tb_clk);
      cnt++;
      if (bus.seqDone) break;
    end
    chk("boot seqDone clk", 32'(cnt), 32'd8);
    waitIdle("boot");

    // IRQ with I clear
    bus.interruptRequest = 1'b1;
    idleCycles(3);
    mkSeq("irq", 1'b0, 1'b0, 8'hFE, 8);
    boundary(1'b0);
    bus.interruptRequest = 1'b0;
    waitIdle("irq");
    idleCycles(3);

    // IRQ masked by I
    bus.interruptRequest = 1'b1;
    bus.iFlag = 1'b1;
    idleCycles(3);
    for (int i = 0; i < 3; i++) begin
      boundary(1'b0);
      #1 chk($sformatf("masked b%0d", i), 32'(bus.seqActive), 32'd0);
    end
    bus.interruptRequest = 1'b0;
    bus.iFlag = 1'b0;
    idleCycles(3);

    // BRK hijacked by NMI edge detected around step 2
    mkSeq("hijack", 1'b0, 1'b1, 8'hFA, 8);
    boundary(1'b1);
    bus.nonMaskableInterrupt = 1'b1;
    waitIdle("hijack");
    boundary(1'b0);
    idleCycles(2);
    chk("hijack no 2nd", 32'(bus.seqActive | bus.seqDone), 32'd0);

    // Held NMI does not retrigger; fresh edge does
    bus.nonMaskableInterrupt = 1'b0;
    idleCycles(4);
    bus.nonMaskableInterrupt = 1'b1;
    idleCycles(4);
    mkSeq("nmi1", 1'b0, 1'b0, 8'hFA, 8);
    boundary(1'b0);
    waitIdle("nmi1");
    for (int i = 0; i < 2; i++) begin
      boundary(1'b0);
      #1 chk($sformatf("nmi held b%0d", i), 32'(bus.seqActive), 32'd0);
    end
    bus.nonMaskableInterrupt = 1'b0;
    idleCycles(4);
    bus.nonMaskableInterrupt = 1'b1;
    idleCycles(4);
    // NMI and BRK at the same boundary: NMI wins, B bit clear
    mkSeq("nmi2", 1'b0, 1'b0, 8'hFA, 8);
    boundary(1'b1);
    waitIdle("nmi2");
    bus.nonMaskableInterrupt = 1'b0;
    idleCycles(3);

    // Reset asserted at step 3 of an IRQ
    bus.interruptRequest = 1'b1;
    idleCycles(3);
    mkSeq("irqAbort", 1'b0, 1'b0, 8'hFE, 4);
    boundary(1'b0);
    idleCycles(3);
    #1 nrst = 1'b0;
    #1 chk("abort outs", 32'(pk()), 32'd0);
    chk("abort sb", 32'(sb.size()), 32'd0);
    bus.interruptRequest = 1'b0;
    mkSeq("reboot", 1'b1, 1'b0, 8'hFC, 8);
    @(negedge tb_clk);
    nrst = 1'b1;
    waitIdle("reboot");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
